instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port imem_req  output  1  fetch request valid this cycle.
REQ-006 The block SHALL have port imem_addr  output  32  fetch byte address, word aligned.
REQ-007 The block SHALL have port imem_rdata  input  32  instruction word, valid exactly one cycle after an accepted imem_req.
REQ-008 The block SHALL have port redirect_valid  input  1  flush and restart fetch (branch/mispredict).
REQ-009 The block SHALL have port redirect_pc  input  32  restart address.
REQ-010 The block SHALL have port ifq_rd_en  input  1  dispatch pops the head entry.
REQ-011 The block SHALL have ports instruction  output  32 and pc  output  32, meaning the head entry (both 0 when empty).
REQ-012 The block SHALL have ports ifq_empty  output  1, ifq_full  output  1 and ifq_count  output  $clog2(DEPTH)+1.

Function
REQ-013 The block SHALL hold fetch_pc; imem_addr SHALL equal fetch_pc; fetch_pc SHALL advance by 4 on each issued request.
REQ-014 imem_req SHALL be 1 iff !rst && !redirect_valid && (ifq_count + pending) < DEPTH, where pending=1 when a response arrives this cycle.
REQ-015 A response arriving in cycle t+1 for a request issued in cycle t SHALL be enqueued at the end of t+1 and be visible at the head in t+2.
REQ-016 With sustained ifq_rd_en and an unstalled memory, throughput SHALL be one instruction per cycle.
REQ-017 ifq_rd_en while ifq_empty SHALL be ignored and leave all state unchanged.
REQ-018 Simultaneous enqueue and dequeue SHALL leave ifq_count unchanged; the FIFO SHALL never overflow.
REQ-019 Read/write pointers SHALL wrap modulo DEPTH.
REQ-020 On redirect_valid, at the next edge the FIFO SHALL empty, fetch_pc SHALL load redirect_pc, and any in-flight response SHALL be discarded.
REQ-021 Redirect SHALL take priority over same-cycle enqueue and dequeue.
REQ-022 The first request after a redirect SHALL issue in the cycle after redirect_valid, to redirect_pc.
REQ-023 Each entry SHALL carry {pc, instruction}; pc SHALL be the address that fetched it.

Reset
REQ-024 While rst=1, at each edge the block SHALL set fetch_pc=RESET_PC, count=0, pointers=0 and pending=0; imem_req SHALL be 0 during reset.
REQ-025 Reset asserted mid-operation SHALL discard all entries and any in-flight response.
REQ-026 In the first cycle after rst deasserts, the block SHALL drive imem_req=1 with imem_addr=RESET_PC.

Configuration
REQ-027 With macro IFQ_NOP_FILTER_EN defined, responses equal to 32'h0000_0013 or 32'h0000_0000 SHALL be dropped, not enqueued (fetch_pc still advances), so dispatch never stalls on a NOP at the head.
REQ-028 With IFQ_NOP_FILTER_EN undefined, every response SHALL be enqueued unchanged.

Structure
REQ-029 The ifq_entry_t struct {pc, instr} and the constant NOP_INSTR=32'h0000_0013 SHALL reside in the shared package tomasulo_pkg.
REQ-030 Storage SHALL be one sub-module, sync_fifo (parameterised width/depth, with flush input); fetch control SHALL remain in instr_fetch_queue.

Verification
REQ-031 The bench SHALL cover: reset release, memory returning addr+1 -> imem_addr 0,4,8 on consecutive cycles, and the first head (pc=0) visible 2 cycles after reset release.
REQ-032 The bench SHALL cover: no pops, DEPTH=8 -> ifq_full after 8 entries, imem_req low, no entry lost or overwritten.
REQ-033 The bench SHALL cover: pop each cycle from full -> count steady once refill begins, order preserved, pointers wrap cleanly.
REQ-034 The bench SHALL cover: redirect to 0x100 with a request in flight -> next cycle ifq_empty=1, stale word absent, next imem_addr=0x100.
REQ-035 The bench SHALL cover: redirect plus pop plus response in the same cycle -> redirect wins, count=0.
REQ-036 The bench SHALL cover: with IFQ_NOP_FILTER_EN, stream 0x13 between two ADDs -> only the 2 ADDs enqueued, with pcs 0 and 8.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the front-end fetch path.
package tomasulo_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] ZERO_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    // Canonical ADDI x0,x0,0 and the all-zero word both count as NOPs.
    function automatic logic is_nop(input logic [31:0] word);
        return (word == NOP_INSTR) || (word == ZERO_INSTR);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; head data reads as zero when empty.
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign empty   = (r_count == '0);
    assign full    = (r_count == CW'(DEPTH));
    assign count   = r_count;
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch control feeding a sync_fifo of {pc, instr} entries.
// Optional IFQ_NOP_FILTER_EN drops NOP responses instead of enqueuing them.
module instr_fetch_queue
    import tomasulo_pkg::*;
#(
    parameter  int          DEPTH    = 8,
    parameter  logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int          CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          ifq_rd_en,
    output logic [31:0]   instruction,
    output logic [31:0]   pc,
    output logic          ifq_empty,
    output logic          ifq_full,
    output logic [CW-1:0] ifq_count
);

    logic [31:0]  r_fetch_pc;
    logic         r_pending;
    logic [31:0]  r_pending_pc;
    logic [CW-1:0] w_occupancy;
    logic         w_keep;
    logic         w_enq;
    logic         w_deq;
    ifq_entry_t   w_wr_entry;
    ifq_entry_t   w_head;

    // Counting the in-flight response guarantees a slot exists when it lands.
    assign w_occupancy = ifq_count + CW'(r_pending);
    assign imem_req    = !rst && !redirect_valid && (w_occupancy < CW'(DEPTH));
    assign imem_addr   = r_fetch_pc;

`ifdef IFQ_NOP_FILTER_EN
    assign w_keep = !is_nop(imem_rdata);
`else
    assign w_keep = 1'b1;
`endif

    assign w_enq      = r_pending && w_keep && !redirect_valid;
    assign w_deq      = ifq_rd_en && !redirect_valid;
    assign w_wr_entry = '{pc: r_pending_pc, instr: imem_rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_pending    <= 1'b0;
            r_pending_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_pending  <= 1'b0;
        end else begin
            r_pending <= imem_req;
            if (imem_req) begin
                r_pending_pc <= r_fetch_pc;
                r_fetch_pc   <= r_fetch_pc + 32'd4;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .wr_en   (w_enq),
        .wr_data (w_wr_entry),
        .rd_en   (w_deq),
        .rd_data (w_head),
        .empty   (ifq_empty),
        .full    (ifq_full),
        .count   (ifq_count)
    );

    assign instruction = w_head.instr;
    assign pc          = w_head.pc;

endmodule
